// File: rtl/cam_color_pkg.sv
// BT.601 YUV->RGB coefficients and offsets for limited and full range, plus the
// shared 8-bit clamp used by the per-pixel calculator.
package cam_color_pkg;

    typedef enum logic {
        MODE_LIMITED = 1'b0,
        MODE_FULL    = 1'b1
    } mode_e;

    // The +128 rounding term and the Y-16 / C-128 biases are folded into the offsets.
    localparam int KY_LIM  = 298;
    localparam int KRV_LIM = 409;
    localparam int KGV_LIM = 208;
    localparam int KGU_LIM = 100;
    localparam int KBU_LIM = 516;
    localparam int OR_LIM  = -56992;
    localparam int OG_LIM  = 34784;
    localparam int OB_LIM  = -70688;

    localparam int KY_FULL  = 256;
    localparam int KRV_FULL = 359;
    localparam int KGV_FULL = 183;
    localparam int KGU_FULL = 88;
    localparam int KBU_FULL = 454;
    localparam int OR_FULL  = -45824;
    localparam int OG_FULL  = 34816;
    localparam int OB_FULL  = -57984;

    function automatic logic [7:0] clamp_u8(input logic signed [31:0] acc);
        logic [7:0] res;
        if (acc < 0)
            res = 8'd0;
        else if (acc >= 32'sd65536)
            res = 8'hff;
        else
            res = acc[15:8];
        return res;
    endfunction

endpackage

// File: rtl/cam_yuv_px_calc.sv
// One pixel's S2 (Y product + shared chroma terms) and S3 (clamp, truncate) stages.
module cam_yuv_px_calc
    import cam_color_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  mode_e                   i_mode,
    input  logic [7:0]              i_y,
    input  logic signed [ACC_W-1:0] i_cr,
    input  logic signed [ACC_W-1:0] i_cg,
    input  logic signed [ACC_W-1:0] i_cb,
    output logic [3*OUT_W-1:0]      o_rgb
);

    logic signed [ACC_W-1:0] w_ky;
    logic signed [ACC_W-1:0] w_yterm;
    logic signed [ACC_W-1:0] r_acc_r;
    logic signed [ACC_W-1:0] r_acc_g;
    logic signed [ACC_W-1:0] r_acc_b;
    logic [7:0]              w_r8;
    logic [7:0]              w_g8;
    logic [7:0]              w_b8;
    logic [3*OUT_W-1:0]      r_rgb;

    assign w_ky    = (i_mode == MODE_FULL) ? ACC_W'(KY_FULL) : ACC_W'(KY_LIM);
    assign w_yterm = w_ky * $signed({{(ACC_W-8){1'b0}}, i_y});

    assign w_r8 = clamp_u8(32'(r_acc_r));
    assign w_g8 = clamp_u8(32'(r_acc_g));
    assign w_b8 = clamp_u8(32'(r_acc_b));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
            r_rgb   <= '0;
        end else if (i_en) begin
            r_acc_r <= w_yterm + i_cr;
            r_acc_g <= w_yterm + i_cg;
            r_acc_b <= w_yterm + i_cb;
            r_rgb   <= {w_r8[7 -: OUT_W], w_g8[7 -: OUT_W], w_b8[7 -: OUT_W]};
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/cam_yuv422_rgb_pipe.sv
// 3-stage YUV422 -> RGB converter, 2 pixels per beat, single global stall enable,
// BT.601 range mode latched at start of frame.
module cam_yuv422_rgb_pipe
    import cam_color_pkg::*;
#(
    parameter int IN_ORDER = 0,
    parameter int OUT_W    = 8,
    parameter int ACC_W    = 20
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cfg_full,
    input  logic [31:0]        s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_user,
    input  logic               s_last,
    output logic [6*OUT_W-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_user,
    output logic               m_last
);

    logic                    w_en;
    logic                    w_acc;
    logic [7:0]              w_y1, w_y2, w_u8, w_v8;
    logic signed [ACC_W-1:0] w_u, w_v;
    logic signed [ACC_W-1:0] w_krv, w_kgv, w_kgu, w_kbu, w_or, w_og, w_ob;
    logic signed [ACC_W-1:0] w_cr, w_cg, w_cb;
    mode_e                   w_beat_mode;
    mode_e                   r_frame_mode;

    logic                    r_v1, r_v2, r_v3;
    logic                    r_u1, r_u2, r_u3;
    logic                    r_l1, r_l2, r_l3;
    logic [7:0]              r_y1, r_y2;
    mode_e                   r_mode1;
    logic signed [ACC_W-1:0] r_cr, r_cg, r_cb;
    logic [3*OUT_W-1:0]      w_rgb1, w_rgb2;

    // Whole pipe moves together: it can advance whenever the output slot is free or drained.
    assign w_en    = ~r_v3 | m_ready;
    assign s_ready = w_en;
    assign w_acc   = s_valid & w_en;

    always_comb begin
        if (IN_ORDER == 0) begin
            w_y1 = s_data[7:0];
            w_u8 = s_data[15:8];
            w_y2 = s_data[23:16];
            w_v8 = s_data[31:24];
        end else begin
            w_u8 = s_data[7:0];
            w_y1 = s_data[15:8];
            w_v8 = s_data[23:16];
            w_y2 = s_data[31:24];
        end
    end

    assign w_beat_mode = s_user ? mode_e'(cfg_full) : r_frame_mode;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            r_frame_mode <= MODE_LIMITED;
        else if (w_acc && s_user)
            r_frame_mode <= mode_e'(cfg_full);
    end

    always_comb begin
        w_krv = ACC_W'(KRV_LIM);
        w_kgv = ACC_W'(KGV_LIM);
        w_kgu = ACC_W'(KGU_LIM);
        w_kbu = ACC_W'(KBU_LIM);
        w_or  = ACC_W'(OR_LIM);
        w_og  = ACC_W'(OG_LIM);
        w_ob  = ACC_W'(OB_LIM);
        if (w_beat_mode == MODE_FULL) begin
            w_krv = ACC_W'(KRV_FULL);
            w_kgv = ACC_W'(KGV_FULL);
            w_kgu = ACC_W'(KGU_FULL);
            w_kbu = ACC_W'(KBU_FULL);
            w_or  = ACC_W'(OR_FULL);
            w_og  = ACC_W'(OG_FULL);
            w_ob  = ACC_W'(OB_FULL);
        end
    end

    // Chroma terms are shared by both pixels of the beat.
    assign w_u  = $signed({{(ACC_W-8){1'b0}}, w_u8});
    assign w_v  = $signed({{(ACC_W-8){1'b0}}, w_v8});
    assign w_cr = w_krv * w_v + w_or;
    assign w_cg = w_og - w_kgv * w_v - w_kgu * w_u;
    assign w_cb = w_kbu * w_u + w_ob;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_u1 <= 1'b0; r_u2 <= 1'b0; r_u3 <= 1'b0;
            r_l1 <= 1'b0; r_l2 <= 1'b0; r_l3 <= 1'b0;
            r_y1 <= '0;
            r_y2 <= '0;
            r_mode1 <= MODE_LIMITED;
            r_cr <= '0;
            r_cg <= '0;
            r_cb <= '0;
        end else if (w_en) begin
            r_v1 <= s_valid;
            r_u1 <= s_valid & s_user;
            r_l1 <= s_valid & s_last;
            r_v2 <= r_v1; r_u2 <= r_u1; r_l2 <= r_l1;
            r_v3 <= r_v2; r_u3 <= r_u2; r_l3 <= r_l2;
            r_y1 <= w_y1;
            r_y2 <= w_y2;
            r_mode1 <= w_beat_mode;
            r_cr <= w_cr;
            r_cg <= w_cg;
            r_cb <= w_cb;
        end
    end

    cam_yuv_px_calc #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_px1 (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_en    (w_en),
        .i_mode  (r_mode1),
        .i_y     (r_y1),
        .i_cr    (r_cr),
        .i_cg    (r_cg),
        .i_cb    (r_cb),
        .o_rgb   (w_rgb1)
    );

    cam_yuv_px_calc #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_px2 (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_en    (w_en),
        .i_mode  (r_mode1),
        .i_y     (r_y2),
        .i_cr    (r_cr),
        .i_cg    (r_cg),
        .i_cb    (r_cb),
        .o_rgb   (w_rgb2)
    );

    assign m_data  = {w_rgb2, w_rgb1};
    assign m_valid = r_v3;
    assign m_user  = r_u3;
    assign m_last  = r_l3;

endmodule

// File: tb/tb_cam_yuv422_rgb_pipe.sv
// Bench for cam_yuv422_rgb_pipe: directed colour points, latency, mode latch,
// clamping, random backpressure against a reference model, reset flush, UYVY/5-bit build.
module tb_cam_yuv422_rgb_pipe;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cfg_full;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_user;
    logic        s_last;
    logic [47:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_user;
    logic        m_last;

    logic        b_cfg;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_sready;
    logic        b_user;
    logic        b_last;
    logic [29:0] b_mdata;
    logic        b_mvalid;
    logic        b_mready;
    logic        b_muser;
    logic        b_mlast;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        tb_mode  = 1'b0;
    logic [49:0] exp_q[$];

    always #5 ACLK = ~ACLK;

    cam_yuv422_rgb_pipe #(.IN_ORDER(0), .OUT_W(8), .ACC_W(20)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .cfg_full(cfg_full),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_user(s_user), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_user(m_user), .m_last(m_last)
    );

    cam_yuv422_rgb_pipe #(.IN_ORDER(1), .OUT_W(5), .ACC_W(20)) dut5 (
        .ACLK(ACLK), .ARESETN(ARESETN), .cfg_full(b_cfg),
        .s_data(b_data), .s_valid(b_valid), .s_ready(b_sready),
        .s_user(b_user), .s_last(b_last),
        .m_data(b_mdata), .m_valid(b_mvalid), .m_ready(b_mready),
        .m_user(b_muser), .m_last(b_mlast)
    );

    // Textbook BT.601 form with explicit biases; returns 8-bit clamped value.
    function automatic logic [7:0] conv(input int y, input int c, input int k_y, input int y_off,
                                        input int k_c1, input int c1, input int k_c2, input int c2);
        int x;
        x = k_y * (y - y_off) + k_c1 * (c1 - 128) + k_c2 * (c2 - 128) + 128;
        if (x < 0) return 8'd0;
        if (x > 65535) return 8'd255;
        return 8'(x / 256 + c * 0);
    endfunction

    function automatic logic [47:0] model(input logic [31:0] d, input logic full);
        int y[2];
        int u, v, ky, yo;
        logic [7:0] r[2], g[2], b[2];
        y[0] = int'(d[7:0]);
        u    = int'(d[15:8]);
        y[1] = int'(d[23:16]);
        v    = int'(d[31:24]);
        ky   = full ? 256 : 298;
        yo   = full ? 0 : 16;
        for (int p = 0; p < 2; p++) begin
            if (full) begin
                r[p] = conv(y[p], 0, ky, yo, 359, v, 0, u);
                g[p] = conv(y[p], 0, ky, yo, -183, v, -88, u);
                b[p] = conv(y[p], 0, ky, yo, 454, u, 0, v);
            end else begin
                r[p] = conv(y[p], 0, ky, yo, 409, v, 0, u);
                g[p] = conv(y[p], 0, ky, yo, -208, v, -100, u);
                b[p] = conv(y[p], 0, ky, yo, 516, u, 0, v);
            end
        end
        return {r[1], g[1], b[1], r[0], g[0], b[0]};
    endfunction

    // Monitor: samples on the falling edge, pushes expected beats on acceptance,
    // pops and compares delivered beats, and checks output hold during stalls.
    initial begin : monitor
        logic [49:0] exp_v;
        logic [49:0] got_v;
        logic [49:0] prev_v;
        logic        prev_stall;
        prev_stall = 1'b0;
        prev_v     = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                prev_stall = 1'b0;
            end else begin
                got_v = {m_user, m_last, m_data};
                if (prev_stall) begin
                    n_assert++;
                    if (!m_valid || got_v !== prev_v) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%0b %h, required v=1 %h", m_valid, got_v, prev_v);
                    end
                end
                if (m_valid && m_ready) begin
                    n_assert++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got %h, required no beat", got_v);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (got_v !== exp_v) begin
                            n_fail++;
                            $display("FAIL sb_beat: got %h, required %h", got_v, exp_v);
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_v     = got_v;
                if (s_valid && s_ready) begin
                    if (s_user) tb_mode = cfg_full;
                    exp_q.push_back({s_user, s_last, model(s_data, tb_mode)});
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
        s_data  = d;
        s_user  = u;
        s_last  = l;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (s_ready) begin
                @(posedge ACLK); #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge ACLK); #1;
        end
        s_valid = 1'b0;
        n_assert++;
        n_fail++;
        $display("FAIL send_timeout: s_ready stayed 0, required 1 within 50 cycles");
    endtask

    // Returns cycles after the acceptance edge until m_valid is seen, -1 if never.
    task automatic wait_out(output logic [47:0] d, output logic u, output logic l, output int lat);
        lat = -1;
        d   = '0;
        u   = 1'b0;
        l   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge ACLK); #1;
            if (m_valid) begin
                d   = m_data;
                u   = m_user;
                l   = m_last;
                lat = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        ARESETN = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        n_assert++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        n_assert++;
        if (m_data !== 48'd0) begin n_fail++; $display("FAIL reset_m_data: got %h, required 0", m_data); end
        n_assert++;
        if (m_user !== 1'b0 || m_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_user_last: got %b%b, required 00", m_user, m_last);
        end
        n_assert++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_limited;
        logic [47:0] d;
        logic        u, l;
        int          lat;
        cfg_full = 1'b0;
        send_beat({8'd128, 8'd16, 8'd128, 8'd16}, 1'b1, 1'b0);
        wait_out(d, u, l, lat);
        // Acceptance cycle counts as cycle 0; m_valid must appear 3 cycles later.
        n_assert++;
        if (lat + 1 !== 3) begin n_fail++; $display("FAIL latency: got %0d, required 3", lat + 1); end
        n_assert++;
        if (d !== 48'h0) begin n_fail++; $display("FAIL limited_black: got %h, required 000000000000", d); end
        n_assert++;
        if (u !== 1'b1) begin n_fail++; $display("FAIL sof_align: got %b, required 1", u); end
        send_beat({8'd128, 8'd235, 8'd128, 8'd235}, 1'b0, 1'b1);
        wait_out(d, u, l, lat);
        n_assert++;
        if (d !== 48'hffffffffffff) begin n_fail++; $display("FAIL limited_white: got %h, required ffffffffffff", d); end
        n_assert++;
        if (l !== 1'b1 || u !== 1'b0) begin n_fail++; $display("FAIL eol_align: got u=%b l=%b, required u=0 l=1", u, l); end
    endtask

    task automatic test_full_mode;
        logic [47:0] d;
        logic        u, l;
        int          lat;
        cfg_full = 1'b1;
        send_beat({8'd128, 8'd128, 8'd128, 8'd128}, 1'b1, 1'b1);
        wait_out(d, u, l, lat);
        n_assert++;
        if (d !== 48'h808080808080) begin n_fail++; $display("FAIL full_grey: got %h, required 808080808080", d); end
        n_assert++;
        if (u !== 1'b1 || l !== 1'b1) begin n_fail++; $display("FAIL one_beat_line: got u=%b l=%b, required 1 1", u, l); end
        cfg_full = 1'b0;
        send_beat({8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b0);
        wait_out(d, u, l, lat);
        n_assert++;
        if (d !== 48'h808080808080) begin n_fail++; $display("FAIL mode_midframe: got %h, required 808080808080", d); end
    endtask

    task automatic test_clamp;
        logic [47:0] d;
        logic        u, l;
        int          lat;
        cfg_full = 1'b0;
        send_beat({8'd255, 8'd255, 8'd128, 8'd255}, 1'b1, 1'b0);
        wait_out(d, u, l, lat);
        n_assert++;
        if (d[23:16] !== 8'd255) begin n_fail++; $display("FAIL clamp_high_r: got %0d, required 255", d[23:16]); end
        send_beat(32'h0, 1'b0, 1'b0);
        wait_out(d, u, l, lat);
        n_assert++;
        if (d[23:16] !== 8'd0 || d[7:0] !== 8'd0) begin
            n_fail++; $display("FAIL clamp_low_rb: got r=%0d b=%0d, required 0 0", d[23:16], d[7:0]);
        end
        n_assert++;
        if (d[15:8] !== 8'd135) begin n_fail++; $display("FAIL clamp_low_g: got %0d, required 135", d[15:8]); end
    endtask

    task automatic test_backpressure;
        int   sent = 0;
        int   cyc  = 0;
        logic acc  = 1'b0;
        s_valid = 1'b0;
        while (sent < 100 && cyc < 3000) begin
            @(posedge ACLK); #1;
            cyc++;
            if (s_valid && acc) begin
                sent++;
                s_valid = 1'b0;
            end
            m_ready  = ($urandom_range(0, 3) != 0);
            cfg_full = 1'($urandom_range(0, 1));
            if (!s_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                s_data  = $urandom;
                s_user  = (sent % 20 == 0);
                s_last  = (sent % 5 == 4);
                s_valid = 1'b1;
            end
            #1;
            acc = s_valid && s_ready;
        end
        s_valid = 1'b0;
        n_assert++;
        if (sent != 100) begin n_fail++; $display("FAIL bp_send: got %0d beats, required 100", sent); end
        m_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge ACLK);
        #1;
        n_assert++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_mid_reset;
        int stale = 0;
        logic [47:0] d;
        logic        u, l;
        int          lat;
        m_ready  = 1'b0;
        cfg_full = 1'b1;
        send_beat({8'd128, 8'd128, 8'd128, 8'd128}, 1'b1, 1'b0);
        send_beat({8'd128, 8'd16, 8'd128, 8'd16}, 1'b0, 1'b0);
        send_beat({8'd128, 8'd235, 8'd128, 8'd235}, 1'b0, 1'b1);
        n_assert++;
        if (m_valid !== 1'b1) begin n_fail++; $display("FAIL flight_full: got m_valid=%b, required 1", m_valid); end
        ARESETN = 1'b0;
        #1;
        n_assert++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got m_valid=%b, required 0", m_valid); end
        exp_q.delete();
        tb_mode  = 1'b0;
        m_ready  = 1'b1;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge ACLK); #1;
            if (m_valid) stale++;
        end
        n_assert++;
        if (stale != 0) begin n_fail++; $display("FAIL stale_beat: got %0d beats, required 0", stale); end
        // No SOF since reset, so cfg_full must be ignored and limited range used.
        cfg_full = 1'b1;
        send_beat({8'd128, 8'd16, 8'd128, 8'd16}, 1'b0, 1'b0);
        wait_out(d, u, l, lat);
        n_assert++;
        if (d !== 48'h0) begin n_fail++; $display("FAIL post_reset_mode: got %h, required 000000000000", d); end
    endtask

    task automatic test_uyvy_w5;
        int lat = -1;
        b_cfg    = 1'b0;
        b_mready = 1'b1;
        b_data   = {8'd235, 8'd128, 8'd16, 8'd128};
        b_user   = 1'b1;
        b_last   = 1'b1;
        b_valid  = 1'b1;
        @(posedge ACLK); #1;
        b_valid = 1'b0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            if (b_mvalid) lat = i;
            else begin @(posedge ACLK); #1; end
        end
        n_assert++;
        if (lat < 0) begin
            n_fail++; $display("FAIL w5_timeout: got no m_valid, required one beat");
        end else begin
            if (b_mdata !== {5'd31, 5'd31, 5'd31, 15'd0}) begin
                n_fail++; $display("FAIL w5_data: got %h, required %h", b_mdata, {5'd31, 5'd31, 5'd31, 15'd0});
            end
        end
        n_assert++;
        if (lat >= 0 && (b_muser !== 1'b1 || b_mlast !== 1'b1)) begin
            n_fail++; $display("FAIL w5_user_last: got %b%b, required 11", b_muser, b_mlast);
        end
    endtask

    initial begin
        cfg_full = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_user   = 1'b0;
        s_last   = 1'b0;
        m_ready  = 1'b1;
        b_cfg    = 1'b0;
        b_data   = '0;
        b_valid  = 1'b0;
        b_user   = 1'b0;
        b_last   = 1'b0;
        b_mready = 1'b1;
        test_reset();
        test_limited();
        test_full_mode();
        test_clamp();
        test_backpressure();
        test_mid_reset();
        test_uyvy_w5();
        repeat (5) @(posedge ACLK);
        #1;
        n_assert++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
